// File: rtl/servant_mdu_seq.sv
// servant_mdu_seq: iterative RV32M multiply/divide unit for the servant CPU
// extension interface. A single 64-bit shift datapath {hi, lo} produces one
// result bit per cycle for both multiply (shift-add) and divide (restoring).
// Optional build macro: SERVANT_MDU_ZERO_SKIP_EN. When it is defined, a zero
// multiplier or divisor skips the iterative phase; results are unchanged.
//
// state | meaning
// IDLE  | waiting for i_valid; latches operands, sign flag and funct3
// CALC  | 32 iterations, one result bit per cycle; abort if i_valid drops
// DONE  | selects and sign-corrects the result, pulses o_ready
module servant_mdu_seq #(
    parameter RESET_STRATEGY = "MINI"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rd,
    output logic        o_ready
);

    localparam bit MINI_RST = (RESET_STRATEGY == "MINI") || (RESET_STRATEGY == "NONE");

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [4:0]  counter;
    logic [2:0]  funct3_q;
    logic        neg_q;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] b;
    logic [31:0] rd_q;

    logic        div_op;
    logic        s1_signed;
    logic        s2_signed;
    logic        rs2_zero;
    logic        neg_calc;
    logic [31:0] rs1_mag;
    logic [31:0] rs2_mag;
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [33:0] div_trial;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] div_sel;
    logic [31:0] result;

    // Request decode: operand signedness, magnitudes and result sign.
    // Signed division by zero keeps the raw dividend so the remainder comes
    // out as rs1 unchanged with no sign fix-up.
    always_comb begin
        div_op    = i_funct3[2];
        rs2_zero  = (i_rs2 == 32'd0);
        if (div_op) begin
            s1_signed = ~i_funct3[0] & ~rs2_zero;
            s2_signed = ~i_funct3[0] & ~rs2_zero;
        end else begin
            s1_signed = (i_funct3[1:0] == 2'b01) || (i_funct3[1:0] == 2'b10);
            s2_signed = (i_funct3[1:0] == 2'b01);
        end
        rs1_mag = (s1_signed && i_rs1[31]) ? (32'd0 - i_rs1) : i_rs1;
        rs2_mag = (s2_signed && i_rs2[31]) ? (32'd0 - i_rs2) : i_rs2;
        if (div_op && i_funct3[1])
            neg_calc = s1_signed & i_rs1[31];
        else
            neg_calc = (s1_signed & i_rs1[31]) ^ (s2_signed & i_rs2[31]);
    end

    // Iteration arithmetic and final result selection.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b} : 33'd0);
        rem_shift = {hi, lo[31]};
        div_trial = {1'b0, rem_shift} - {2'b00, b};
        prod      = {hi, lo};
        prod_fix  = neg_q ? (64'd0 - prod) : prod;
        div_sel   = funct3_q[1] ? hi : lo;
        if (funct3_q[2])
            result = neg_q ? (32'd0 - div_sel) : div_sel;
        else if (funct3_q[1:0] == 2'b00)
            result = prod_fix[31:0];
        else
            result = prod_fix[63:32];
    end

    // Sequencer and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_ready <= 1'b0;
            if (!MINI_RST) begin
                counter  <= 5'd0;
                funct3_q <= 3'd0;
                neg_q    <= 1'b0;
                hi       <= 32'd0;
                lo       <= 32'd0;
                b        <= 32'd0;
                rd_q     <= 32'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= 1'b0;
                    // o_ready high means the CPU has not yet seen completion
                    // of the previous request, so its valid is stale.
                    if (i_valid && !o_ready) begin
                        funct3_q <= i_funct3;
                        neg_q    <= neg_calc;
                        counter  <= 5'd31;
                        hi       <= 32'd0;
                        state    <= CALC;
                        if (div_op) begin
                            lo <= rs1_mag;
                            b  <= rs2_mag;
                        end else begin
                            lo <= rs2_mag;
                            b  <= rs1_mag;
                        end
`ifdef SERVANT_MDU_ZERO_SKIP_EN
                        if (rs2_zero) begin
                            state <= DONE;
                            neg_q <= 1'b0;
                            if (div_op) begin
                                hi <= i_rs1;
                                lo <= 32'hFFFF_FFFF;
                            end else begin
                                lo <= 32'd0;
                            end
                        end
`endif
                    end
                end
                CALC: begin
                    if (!i_valid) begin
                        state <= IDLE;
                    end else begin
                        if (funct3_q[2]) begin
                            if (!div_trial[33]) begin
                                hi <= div_trial[31:0];
                                lo <= {lo[30:0], 1'b1};
                            end else begin
                                hi <= rem_shift[31:0];
                                lo <= {lo[30:0], 1'b0};
                            end
                        end else begin
                            hi <= mul_sum[32:1];
                            lo <= {mul_sum[0], lo[31:1]};
                        end
                        counter <= counter - 5'd1;
                        if (counter == 5'd0)
                            state <= DONE;
                    end
                end
                DONE: begin
                    o_ready <= 1'b1;
                    rd_q    <= result;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd = o_ready ? rd_q : 32'd0;

endmodule
